// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: picks sequential/redirect/reset PC,
// drives PC hold and IF/ID flush, and tracks halt and control faults.
module pc_sequencer #(
   parameter logic [31:0] RESET_ADDR = 32'd0,
   parameter logic [31:0] HALT_ADDR  = 32'd248,
   parameter int          STALL_MAX  = 15
) (
   input  logic        clk_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        load_use_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        fault_clr_i,
   output logic [31:0] pc_next_o,
   output logic        pc_hold_o,
   output logic        ifid_flush_o,
   output logic        halted_o,
   output logic        fault_o,
   output logic [1:0]  fault_code_o,
   output logic [7:0]  fault_count_o
);

   typedef enum logic [2:0] {BOOT, RUN, STALL, HALT, FAULT} state_t;

   localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);
   localparam logic [1:0] CODE_NONE   = 2'b00;
   localparam logic [1:0] CODE_ALIGN  = 2'b01;
   localparam logic [1:0] CODE_WDOG   = 2'b10;

   state_t      state_reg, state_next;
   logic [7:0]  stall_cnt_reg, stall_cnt_next;
   logic [1:0]  fault_code_reg, fault_code_next;
   logic [7:0]  fault_count_reg;
   logic        halted_reg;
   logic        fault_reg;

   logic        misaligned;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        at_halt;

   // A taken branch is older than the ID-stage jump, so it owns the redirect.
   assign misaligned = (branch_taken_i && (branch_target_i[1:0] != 2'b00)) ||
                       (jump_i && !branch_taken_i && (jump_target_i[1:0] != 2'b00));
   assign redirect        = branch_taken_i || jump_i;
   assign redirect_target = branch_taken_i ? branch_target_i : jump_target_i;
   assign at_halt         = (pc_i == HALT_ADDR);

   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         state_reg       <= BOOT;
         stall_cnt_reg   <= 8'd0;
         fault_code_reg  <= CODE_NONE;
         fault_count_reg <= 8'd0;
         halted_reg      <= 1'b0;
         fault_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         stall_cnt_reg  <= stall_cnt_next;
         fault_code_reg <= fault_code_next;
         halted_reg     <= halted_reg || (state_next == HALT);
         fault_reg      <= (state_next == FAULT);
         if ((state_next == FAULT) && (state_reg != FAULT) && (fault_count_reg != 8'hFF))
            fault_count_reg <= fault_count_reg + 8'd1;
      end
   end

   always_comb begin
      state_next      = state_reg;
      stall_cnt_next  = stall_cnt_reg;
      fault_code_next = fault_code_reg;
      case (state_reg)
         BOOT: begin
            state_next      = RUN;
            stall_cnt_next  = 8'd0;
            fault_code_next = CODE_NONE;
         end
         RUN, STALL: begin
            if (misaligned) begin
               state_next      = FAULT;
               fault_code_next = CODE_ALIGN;
            end else if (redirect) begin
               state_next     = RUN;
               stall_cnt_next = 8'd0;
            end else if (at_halt) begin
               state_next = HALT;
            end else if (load_use_i) begin
               if (stall_cnt_reg < STALL_LIMIT) begin
                  state_next     = STALL;
                  stall_cnt_next = stall_cnt_reg + 8'd1;
               end else begin
                  state_next      = FAULT;
                  fault_code_next = CODE_WDOG;
               end
            end else begin
               state_next     = RUN;
               stall_cnt_next = 8'd0;
            end
         end
         HALT: state_next = HALT;
         FAULT: begin
            if (fault_clr_i) begin
               state_next      = RUN;
               stall_cnt_next  = 8'd0;
               fault_code_next = CODE_NONE;
            end
         end
         default: state_next = BOOT;
      endcase
   end

   // Default is "hold the current PC, no squash"; each case overrides only what differs.
   always_comb begin
      pc_next_o    = pc_i;
      pc_hold_o    = 1'b1;
      ifid_flush_o = 1'b0;
      case (state_reg)
         BOOT: pc_next_o = RESET_ADDR;
         RUN, STALL: begin
            if (misaligned) begin
               ifid_flush_o = 1'b1;
            end else if (redirect) begin
               pc_next_o    = redirect_target;
               pc_hold_o    = 1'b0;
               ifid_flush_o = 1'b1;
            end else if (!at_halt && !load_use_i) begin
               pc_next_o = pc_i + 32'd4;
               pc_hold_o = 1'b0;
            end
         end
         HALT: pc_next_o = HALT_ADDR;
         FAULT: begin
            if (fault_clr_i) begin
               pc_next_o    = RESET_ADDR;
               pc_hold_o    = 1'b0;
               ifid_flush_o = 1'b1;
            end
         end
         default: pc_next_o = RESET_ADDR;
      endcase
   end

   assign halted_o      = halted_reg;
   assign fault_o       = fault_reg;
   assign fault_code_o  = fault_code_reg;
   assign fault_count_o = fault_count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected next-PC/hold/flush are queued as
// each cycle's inputs are driven and retired once the outputs settle.
module tb_pc_sequencer;

   logic        clk_i = 1'b0;
   logic        start_i;
   logic [31:0] pc_i;
   logic        load_use_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic        fault_clr_i;
   logic [31:0] pc_next_o;
   logic        pc_hold_o;
   logic        ifid_flush_o;
   logic        halted_o;
   logic        fault_o;
   logic [1:0]  fault_code_o;
   logic [7:0]  fault_count_o;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        hold;
      logic        flush;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;

   pc_sequencer dut (
      .clk_i           (clk_i),
      .start_i         (start_i),
      .pc_i            (pc_i),
      .load_use_i      (load_use_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .fault_clr_i     (fault_clr_i),
      .pc_next_o       (pc_next_o),
      .pc_hold_o       (pc_hold_o),
      .ifid_flush_o    (ifid_flush_o),
      .halted_o        (halted_o),
      .fault_o         (fault_o),
      .fault_code_o    (fault_code_o),
      .fault_count_o   (fault_count_o)
   );

   // Drives one cycle of inputs at the falling edge and queues the expected outputs.
   task automatic drive(input string nm, input logic [31:0] pc, input logic lu,
                        input logic bt, input logic [31:0] btt, input logic j,
                        input logic [31:0] jt, input logic clr,
                        input logic [31:0] e_pc, input logic e_hold, input logic e_flush);
      exp_t x;
      @(negedge clk_i);
      pc_i = pc; load_use_i = lu; branch_taken_i = bt; branch_target_i = btt;
      jump_i = j; jump_target_i = jt; fault_clr_i = clr;
      x.name = nm; x.pc = e_pc; x.hold = e_hold; x.flush = e_flush;
      sb.push_back(x);
   endtask

   task automatic test_reset;
      exp_t x;
      start_i = 1'b0; pc_i = 32'h0; load_use_i = 1'b0; branch_taken_i = 1'b0;
      branch_target_i = 32'h0; jump_i = 1'b0; jump_target_i = 32'h0; fault_clr_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++;
      if ({halted_o, fault_o, fault_code_o, fault_count_o} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_regs: got halted=%b fault=%b code=%b count=%0d, want all 0",
                  halted_o, fault_o, fault_code_o, fault_count_o);
      end else $display("txn reset_regs ok");
      x.name = "boot"; x.pc = 32'h0; x.hold = 1'b1; x.flush = 1'b0;
      sb.push_back(x);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      @(negedge clk_i);
      start_i = 1'b1;
   endtask

   task automatic test_sequential;
      for (int i = 0; i < 3; i++) begin
         drive("seq", 32'(i * 4), 0, 0, 0, 0, 0, 0, 32'((i + 1) * 4), 1'b0, 1'b0);
         #1; e = sb.pop_front(); n_checks++;
         if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
            n_fail++;
            $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                     e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
         end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      end
      drive("wrap", 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
   endtask

   task automatic test_stall;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive("stall", 32'h20, 1, 0, 0, 0, 0, 0, 32'h20, 1'b1, 1'b0);
         else       drive("stall_release", 32'h20, 0, 0, 0, 0, 0, 0, 32'h24, 1'b0, 1'b0);
         #1; e = sb.pop_front(); n_checks++;
         if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
            n_fail++;
            $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                     e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
         end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
         @(posedge clk_i); #1; n_checks++;
         if (fault_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_nofault: got fault=%b, want 0", fault_o);
         end
      end
   endtask

   task automatic test_redirect;
      drive("branch_wins", 32'h28, 1, 1, 32'h80, 1, 32'h40, 0, 32'h80, 1'b0, 1'b1);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      drive("jump", 32'h80, 0, 0, 32'h0, 1, 32'h40, 0, 32'h40, 1'b0, 1'b1);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
   endtask

   task automatic test_misaligned;
      drive("misalign_jump", 32'h40, 0, 0, 32'h0, 1, 32'h42, 0, 32'h40, 1'b1, 1'b1);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      @(posedge clk_i); #1; n_checks++;
      if ({fault_o, fault_code_o, fault_count_o} !== {1'b1, 2'b01, 8'd1}) begin
         n_fail++;
         $display("FAIL fault_align: got fault=%b code=%b count=%0d, want 1 01 1",
                  fault_o, fault_code_o, fault_count_o);
      end else $display("txn fault_align ok");
      // Redirect inputs must be ignored while faulted.
      drive("fault_ignore", 32'h44, 1, 1, 32'h80, 0, 32'h0, 0, 32'h44, 1'b1, 1'b0);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      drive("fault_clr", 32'h44, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 1'b0, 1'b1);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      @(posedge clk_i); #1; n_checks++;
      if ({fault_o, fault_code_o, fault_count_o} !== {1'b0, 2'b00, 8'd1}) begin
         n_fail++;
         $display("FAIL fault_cleared: got fault=%b code=%b count=%0d, want 0 00 1",
                  fault_o, fault_code_o, fault_count_o);
      end else $display("txn fault_cleared ok");
      drive("after_clr", 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 1'b0, 1'b0);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
   endtask

   task automatic test_watchdog;
      for (int i = 1; i <= 17; i++) begin
         drive("wdog_stall", 32'h30, 1, 0, 32'h0, 0, 32'h0, 0, 32'h30, 1'b1, 1'b0);
         #1; e = sb.pop_front(); n_checks++;
         if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
            n_fail++;
            $display("FAIL %s[%0d]: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                     e.name, i, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
         end
         @(posedge clk_i); #1; n_checks++;
         if (i < 16) begin
            if (fault_o !== 1'b0) begin
               n_fail++;
               $display("FAIL wdog_early[%0d]: got fault=%b, want 0", i, fault_o);
            end
         end else if ({fault_o, fault_code_o, fault_count_o} !== {1'b1, 2'b10, 8'd2}) begin
            n_fail++;
            $display("FAIL wdog_fault[%0d]: got fault=%b code=%b count=%0d, want 1 10 2",
                     i, fault_o, fault_code_o, fault_count_o);
         end
         $display("txn wdog cycle %0d fault=%b code=%b", i, fault_o, fault_code_o);
      end
   endtask

   task automatic test_reset_mid_fault;
      @(negedge clk_i);
      start_i = 1'b0;
      #1; n_checks++;
      if ({halted_o, fault_o, fault_code_o, fault_count_o} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_mid_fault: got halted=%b fault=%b code=%b count=%0d, want all 0",
                  halted_o, fault_o, fault_code_o, fault_count_o);
      end else $display("txn reset_mid_fault ok");
      @(negedge clk_i);
      start_i = 1'b1;
   endtask

   task automatic test_halt;
      drive("halt_entry", 32'd248, 1, 0, 32'h0, 0, 32'h0, 0, 32'd248, 1'b1, 1'b0);
      #1; e = sb.pop_front(); n_checks++;
      if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
         n_fail++;
         $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                  e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
      end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1; n_checks++;
         if ({halted_o, fault_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL halted[%0d]: got halted=%b fault=%b, want 1 0", i, halted_o, fault_o);
         end
         drive("halt_ignore", 32'h10 + 32'(i), 1, 1, 32'h81, 1, 32'h42, 1, 32'd248, 1'b1, 1'b0);
         #1; e = sb.pop_front(); n_checks++;
         if ({pc_next_o, pc_hold_o, ifid_flush_o} !== {e.pc, e.hold, e.flush}) begin
            n_fail++;
            $display("FAIL %s: got pc=%h hold=%b flush=%b, want pc=%h hold=%b flush=%b",
                     e.name, pc_next_o, pc_hold_o, ifid_flush_o, e.pc, e.hold, e.flush);
         end else $display("txn %s pc_next=%h ok", e.name, pc_next_o);
      end
      start_i = 1'b0;
      #1; n_checks++;
      if ({halted_o, fault_o, fault_code_o, fault_count_o, pc_next_o, pc_hold_o} !==
          {1'b0, 1'b0, 2'b00, 8'd0, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_halt: got halted=%b count=%0d pc=%h hold=%b, want 0 0 0 1",
                  halted_o, fault_count_o, pc_next_o, pc_hold_o);
      end else $display("txn reset_mid_halt ok");
      @(negedge clk_i);
      start_i = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_sequential;
      test_stall;
      test_redirect;
      test_misaligned;
      test_watchdog;
      test_reset_mid_fault;
      test_halt;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
